// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer that time-shares one external 4-bit
// ripple-carry adder, stepping least-significant nibble first.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam int unsigned BW = IW + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry_q;
  logic [IW-1:0]   idx;
  logic [BW-1:0]   base;

  // Bit offset of the nibble currently being processed.
  assign base = {idx, 2'b00};

  // Adder drive: selected operand nibbles while running, quiet otherwise.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[base +: 4];
      add_b   = b_reg[base +: 4];
      add_cin = carry_q;
    end
  end

  // Sequencer: latch operands on start, step one nibble per clock, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            carry_q   <= sub;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          result[base +: 4] <= add_sum;
          carry_q           <= add_cout;
          if (idx == IW'(NIBBLES - 1)) begin
            // Final nibble: its sign bits decide signed overflow.
            carry_out <= add_cout;
            overflow  <= (add_a[3] == add_b[3]) && (add_sum[3] != add_a[3]);
            idx       <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: three instances (4, 2 and 8 nibbles),
// each wired to a behavioural 4-bit adder, checked every cycle against an
// arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start_v [3] = '{default: 1'b0};
  logic        sub_v   [3] = '{default: 1'b0};
  logic [31:0] opa_v   [3] = '{default: 32'h0};
  logic [31:0] opb_v   [3] = '{default: 32'h0};

  logic [31:0] res_v  [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic        cout_v [3];
  logic        ovf_v  [3];
  logic [3:0]  aa_v   [3];
  logic [3:0]  ab_v   [3];
  logic        acin_v [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic int unsigned nib_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 2 : 8);
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    longint unsigned m;
    m = (64'd1 << (4 * nib_of(i))) - 64'd1;
    return 32'(m);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned NG = (g == 0) ? 4 : ((g == 1) ? 2 : 8);
    logic [4*NG-1:0] result;
    logic [3:0]      add_a, add_b, add_sum;
    logic            add_cin, add_cout, busy, done, carry_out, overflow;

    nibble_serial_adder_ctrl #(.NIBBLES(NG)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_v[g]),
      .sub      (sub_v[g]),
      .op_a     (opa_v[g][4*NG-1:0]),
      .op_b     (opb_v[g][4*NG-1:0]),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .carry_out(carry_out),
      .overflow (overflow)
    );

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    assign res_v[g]  = 32'(result);
    assign busy_v[g] = busy;
    assign done_v[g] = done;
    assign cout_v[g] = carry_out;
    assign ovf_v[g]  = overflow;
    assign aa_v[g]   = add_a;
    assign ab_v[g]   = add_b;
    assign acin_v[g] = add_cin;
  end

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, i, $time, got, exp);
    end
  endtask

  // Reference arithmetic: W-bit add or subtract via two's complement.
  function automatic void ref_op(input int unsigned n, input logic [31:0] a, input logic [31:0] b,
                                 input logic s, output logic [31:0] bb, output logic [31:0] r,
                                 output logic c, output logic v);
    longint unsigned mask, la, lb, sum;
    int unsigned w;
    w    = 4 * n;
    mask = (64'd1 << w) - 64'd1;
    la   = {32'd0, a} & mask;
    lb   = s ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    sum  = la + lb + {63'd0, s};
    r    = 32'(sum & mask);
    bb   = 32'(lb);
    c    = sum[w];
    v    = (la[w-1] == lb[w-1]) && (sum[w-1] != la[w-1]);
  endfunction

  // Carry entering nibble k = carry out of the low k nibbles added as one number.
  function automatic logic cin_at(input logic [31:0] a, input logic [31:0] bb, input logic s, input int k);
    longint unsigned low, t;
    low = (64'd1 << (4 * k)) - 64'd1;
    t   = ({32'd0, a} & low) + ({32'd0, bb} & low) + {63'd0, s};
    return t[4*k];
  endfunction

  // Model state: phase 0 = idle, 1..n = step n, n+1 = done cycle.
  int unsigned phase [3] = '{default: 0};
  logic [31:0] exp_r [3] = '{default: 32'h0};
  logic        exp_c [3] = '{default: 1'b0};
  logic        exp_v [3] = '{default: 1'b0};
  logic [31:0] pend_r[3] = '{default: 32'h0};
  logic        pend_c[3] = '{default: 1'b0};
  logic        pend_v[3] = '{default: 1'b0};
  logic [31:0] m_a   [3] = '{default: 32'h0};
  logic [31:0] m_bb  [3] = '{default: 32'h0};
  logic        m_s   [3] = '{default: 1'b0};

  // Model timing update.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        phase[i] = 0;
        exp_r[i] = 32'h0;
        exp_c[i] = 1'b0;
        exp_v[i] = 1'b0;
      end else if (phase[i] == 0) begin
        if (start_v[i]) begin
          ref_op(nib_of(i), opa_v[i], opb_v[i], sub_v[i], m_bb[i], pend_r[i], pend_c[i], pend_v[i]);
          m_a[i]   = opa_v[i] & mask_of(i);
          m_s[i]   = sub_v[i];
          exp_r[i] = 32'h0;
          exp_c[i] = 1'b0;
          exp_v[i] = 1'b0;
          phase[i] = 1;
        end
      end else if (phase[i] < nib_of(i)) begin
        phase[i] = phase[i] + 1;
      end else if (phase[i] == nib_of(i)) begin
        phase[i] = nib_of(i) + 1;
        exp_r[i] = pend_r[i];
        exp_c[i] = pend_c[i];
        exp_v[i] = pend_v[i];
      end else begin
        phase[i] = 0;
      end
    end
  end

  // Compare process: every cycle, every instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int unsigned n;
      int k;
      n = nib_of(i);
      chk("busy", i, 32'(busy_v[i]), 32'(phase[i] != 0));
      chk("done", i, 32'(done_v[i]), 32'(phase[i] == n + 1));
      if (phase[i] == 0 || phase[i] == n + 1) begin
        chk("result", i, res_v[i], exp_r[i]);
        chk("carry_out", i, 32'(cout_v[i]), 32'(exp_c[i]));
        chk("overflow", i, 32'(ovf_v[i]), 32'(exp_v[i]));
        chk("add_a_idle", i, 32'(aa_v[i]), 32'h0);
        chk("add_b_idle", i, 32'(ab_v[i]), 32'h0);
        chk("add_cin_idle", i, 32'(acin_v[i]), 32'h0);
      end else begin
        k = int'(phase[i]) - 1;
        chk("add_a", i, 32'(aa_v[i]), (m_a[i] >> (4 * k)) & 32'hF);
        chk("add_b", i, 32'(ab_v[i]), (m_bb[i] >> (4 * k)) & 32'hF);
        chk("add_cin", i, 32'(acin_v[i]), 32'(cin_at(m_a[i], m_bb[i], m_s[i], k)));
      end
    end
  end

  // One operation on instance i; optional noise on inputs while busy.
  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s, input bit noisy);
    bit got;
    @(negedge clk);
    start_v[i] = 1'b1;
    sub_v[i]   = s;
    opa_v[i]   = a;
    opb_v[i]   = b;
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (done_v[i]) begin
        got = 1'b1;
        start_v[i] = 1'b0;
        break;
      end
      if (noisy) begin
        start_v[i] = 1'($urandom_range(0, 1));
        sub_v[i]   = 1'($urandom_range(0, 1));
        opa_v[i]   = $urandom & mask_of(i);
        opb_v[i]   = $urandom & mask_of(i);
      end else begin
        start_v[i] = 1'b0;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout inst%0d: got no done expected done within 40 cycles", i);
      start_v[i] = 1'b0;
    end
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic s, input bit noisy,
                          input logic [31:0] er, input logic ec, input logic ev);
    run_op(0, a, b, s, noisy);
    chk("lit_result", 0, res_v[0], er);
    chk("lit_carry", 0, 32'(cout_v[0]), 32'(ec));
    chk("lit_ovf", 0, 32'(ovf_v[0]), 32'(ev));
  endtask

  task automatic rand_ops(input int i, input int cnt);
    for (int j = 0; j < cnt; j++) begin
      run_op(i, $urandom & mask_of(i), $urandom & mask_of(i), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bb, r;
    logic c, v;
    logic [3:0] cseq;

    // Pin the reference model to hand-computed values.
    ref_op(4, 32'h1234, 32'h0FCD, 1'b0, bb, r, c, v);
    chk("model_add", 0, {r[29:0], c, v}, {32'h2201, 2'b00} & 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) cseq[k] = cin_at(32'h1234, bb, 1'b0, k);
    chk("model_cin_seq", 0, 32'(cseq), 32'hE);
    ref_op(4, 32'h7FFF, 32'h0001, 1'b0, bb, r, c, v);
    chk("model_ovf", 0, {r[29:0], c, v}, {32'h8000, 2'b01} & 32'hFFFF_FFFF);
    ref_op(4, 32'h8000, 32'h0001, 1'b1, bb, r, c, v);
    chk("model_sub", 0, {r[29:0], c, v}, {32'h7FFF, 2'b11} & 32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    chk("reset_result", 0, res_v[0], 32'h0);
    chk("reset_busy", 0, 32'(busy_v[0]), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    directed(32'h1234, 32'h0FCD, 1'b0, 1'b0, 32'h2201, 1'b0, 1'b0);
    directed(32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0);
    directed(32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
    directed(32'h0005, 32'h0007, 1'b1, 1'b0, 32'hFFFE, 1'b0, 1'b0);
    directed(32'h8000, 32'h0001, 1'b1, 1'b0, 32'h7FFF, 1'b1, 1'b1);
    directed(32'h1111, 32'h2222, 1'b0, 1'b1, 32'h3333, 1'b0, 1'b0);

    // Reset in the second RUN cycle: outputs clear at once, no done follows.
    @(negedge clk);
    start_v[0] = 1'b1;
    sub_v[0]   = 1'b0;
    opa_v[0]   = 32'h4321;
    opb_v[0]   = 32'h1111;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 0, 32'(busy_v[0]), 32'h0);
    chk("rst_done", 0, 32'(done_v[0]), 32'h0);
    chk("rst_result", 0, res_v[0], 32'h0);
    chk("rst_add", 0, {23'd0, aa_v[0], ab_v[0], acin_v[0]}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    directed(32'h0001, 32'h0002, 1'b0, 1'b0, 32'h0003, 1'b0, 1'b0);

    fork
      rand_ops(1, 500);
      rand_ops(2, 500);
    join

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
